// File: rtl/axi_stream_pkt_arb_if.sv
// Stream channel (if_axi_stream): payload with sop/eop/err framing and a val/rdy handshake.
interface axi_stream_pkt_arb_if #(
    parameter int unsigned DAT_BITS = 256,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned MOD_BITS = $clog2(DAT_BITS / 8)
);
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;
    logic                sop;
    logic                eop;
    logic                err;
    logic                val;
    logic                rdy;

    modport source (output dat, ctl, mod, sop, eop, err, val, input rdy);
    modport sink   (input dat, ctl, mod, sop, eop, err, val, output rdy);
endinterface

// File: rtl/axi_stream_pkt_arb.sv
// Packet-aware round-robin arbiter: NUM_IN stream sources share one output,
// a grant is held from the first accepted beat through the eop beat.
module axi_stream_pkt_arb #(
    parameter int unsigned NUM_IN   = 4,
    parameter int unsigned DAT_BITS = 256,
    parameter int unsigned MOD_BITS = $clog2(DAT_BITS / 8),
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned PIPE     = 1,
    parameter int unsigned TAG_CTL  = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    axi_stream_pkt_arb_if.sink          i_axi [NUM_IN],
    axi_stream_pkt_arb_if.source        o_axi,
    output logic [$clog2(NUM_IN)-1:0]   o_sel,
    output logic                        o_lock,
    output logic [31:0]                 o_pkt_cnt
);
    localparam int unsigned SEL_BITS = $clog2(NUM_IN);

    typedef struct packed {
        logic [DAT_BITS-1:0] dat;
        logic [CTL_BITS-1:0] ctl;
        logic [MOD_BITS-1:0] mod;
        logic                sop;
        logic                eop;
        logic                err;
    } beat_t;

    typedef enum logic {IDLE, LOCK} state_t;

    beat_t               in_beat [NUM_IN];
    logic [NUM_IN-1:0]   in_val;
    logic [NUM_IN-1:0]   in_rdy_c;

    state_t              state_q;
    logic [SEL_BITS-1:0] sel_q;
    logic                lock_q;
    logic [31:0]         pkt_cnt_q;

    logic [SEL_BITS-1:0] pick_c;
    logic                any_c;
    beat_t               sel_beat_c;
    logic                sel_val_c;
    logic                stg_rdy_c;
    logic                xfer_c;
    beat_t               out_beat_c;
    logic                out_val_c;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        assign in_beat[k] = '{dat: i_axi[k].dat, ctl: i_axi[k].ctl, mod: i_axi[k].mod,
                              sop: i_axi[k].sop, eop: i_axi[k].eop, err: i_axi[k].err};
        assign in_val[k]    = i_axi[k].val;
        assign i_axi[k].rdy = in_rdy_c[k];
    end

    // Round-robin search starting just after the last grant.
    always_comb begin
        pick_c = sel_q;
        any_c  = 1'b0;
        for (int unsigned i = 1; i <= NUM_IN; i++) begin
            if (!any_c && in_val[SEL_BITS'((32'(sel_q) + i) % NUM_IN)]) begin
                pick_c = SEL_BITS'((32'(sel_q) + i) % NUM_IN);
                any_c  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_beat_c = in_beat[sel_q];
        if (TAG_CTL != 0) begin
            sel_beat_c.ctl[SEL_BITS-1:0] = sel_q;
        end
        sel_val_c = lock_q && in_val[sel_q];
        xfer_c    = sel_val_c && stg_rdy_c;
    end

    always_comb begin
        in_rdy_c = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            in_rdy_c[k] = !i_rst && lock_q && (sel_q == SEL_BITS'(k)) && stg_rdy_c;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_BITS'(NUM_IN - 1);
            lock_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_c) begin
                        sel_q   <= pick_c;
                        lock_q  <= 1'b1;
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if (xfer_c && sel_beat_c.eop) begin
                        lock_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    lock_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    if (PIPE != 0) begin : g_pipe
        // Two-entry skid: accepting while one entry drains keeps 1 beat/cycle.
        beat_t      mem_q [2];
        logic       wr_ptr_q;
        logic       rd_ptr_q;
        logic [1:0] cnt_q;
        logic [1:0] cnt_d;
        logic       pop_c;

        assign stg_rdy_c  = (cnt_q != 2'd2);
        assign out_val_c  = (cnt_q != 2'd0);
        assign out_beat_c = mem_q[rd_ptr_q];
        assign pop_c      = out_val_c && o_axi.rdy;
        assign cnt_d      = cnt_q + 2'(xfer_c) - 2'(pop_c);

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                cnt_q    <= 2'd0;
            end else begin
                if (xfer_c) begin
                    mem_q[wr_ptr_q] <= sel_beat_c;
                    wr_ptr_q        <= !wr_ptr_q;
                end
                if (pop_c) begin
                    rd_ptr_q <= !rd_ptr_q;
                end
                cnt_q <= cnt_d;
            end
        end
    end else begin : g_flow
        assign stg_rdy_c  = o_axi.rdy;
        assign out_val_c  = sel_val_c;
        assign out_beat_c = sel_beat_c;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pkt_cnt_q <= 32'd0;
        end else if (out_val_c && o_axi.rdy && out_beat_c.eop) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign o_axi.dat = out_beat_c.dat;
    assign o_axi.ctl = out_beat_c.ctl;
    assign o_axi.mod = out_beat_c.mod;
    assign o_axi.sop = out_beat_c.sop;
    assign o_axi.eop = out_beat_c.eop;
    assign o_axi.err = out_beat_c.err;
    assign o_axi.val = out_val_c;

    assign o_sel     = sel_q;
    assign o_lock    = lock_q;
    assign o_pkt_cnt = pkt_cnt_q;
endmodule

// File: tb/tb_axi_stream_pkt_arb.sv
// Directed bench: a registered-output arbiter (u_dut) and a pass-through,
// ctl-tagging arbiter (u_tag) driven through per-source beat queues.
module tb_axi_stream_pkt_arb;
    logic clk;
    logic rst;

    typedef struct {
        int          src;
        logic [31:0] dat;
        logic [7:0]  ctl;
        logic        sop;
        logic        eop;
    } tb_beat_t;

    tb_beat_t    bq[$];
    logic [31:0] obs_q[$];
    int          sel_log[$];
    int          occ;
    int          n_assert;
    int          n_fail;

    logic [31:0] d_dat [4];
    logic [7:0]  d_ctl [4];
    logic [3:0]  d_sop, d_eop, d_val, d_rdy;
    logic        o_rdy;
    logic [1:0]  sel1;
    logic        lock1;
    logic [31:0] pkt1;

    logic [31:0] t3_dat;
    logic [7:0]  t3_ctl;
    logic        t3_sop, t3_eop, t3_err, t3_val;
    logic [3:0]  t_rdy;
    logic        o2_rdy;
    logic [1:0]  sel2;
    logic        lock2;
    logic [31:0] pkt2;

    axi_stream_pkt_arb_if #(.DAT_BITS(32), .CTL_BITS(8), .MOD_BITS(2)) in_if [4] ();
    axi_stream_pkt_arb_if #(.DAT_BITS(32), .CTL_BITS(8), .MOD_BITS(2)) out_if ();
    axi_stream_pkt_arb_if #(.DAT_BITS(32), .CTL_BITS(8), .MOD_BITS(2)) t_if [4] ();
    axi_stream_pkt_arb_if #(.DAT_BITS(32), .CTL_BITS(8), .MOD_BITS(2)) t_out ();

    for (genvar k = 0; k < 4; k++) begin : g_if
        assign in_if[k].dat = d_dat[k];
        assign in_if[k].ctl = d_ctl[k];
        assign in_if[k].mod = 2'b11;
        assign in_if[k].sop = d_sop[k];
        assign in_if[k].eop = d_eop[k];
        assign in_if[k].err = 1'b0;
        assign in_if[k].val = d_val[k];
        assign d_rdy[k]     = in_if[k].rdy;
        assign t_if[k].dat  = (k == 3) ? t3_dat : 32'd0;
        assign t_if[k].ctl  = (k == 3) ? t3_ctl : 8'd0;
        assign t_if[k].mod  = 2'b00;
        assign t_if[k].sop  = (k == 3) ? t3_sop : 1'b0;
        assign t_if[k].eop  = (k == 3) ? t3_eop : 1'b0;
        assign t_if[k].err  = (k == 3) ? t3_err : 1'b0;
        assign t_if[k].val  = (k == 3) ? t3_val : 1'b0;
        assign t_rdy[k]     = t_if[k].rdy;
    end
    assign out_if.rdy = o_rdy;
    assign t_out.rdy  = o2_rdy;

    axi_stream_pkt_arb #(.NUM_IN(4), .DAT_BITS(32), .MOD_BITS(2), .CTL_BITS(8),
                         .PIPE(1), .TAG_CTL(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_axi(in_if), .o_axi(out_if),
        .o_sel(sel1), .o_lock(lock1), .o_pkt_cnt(pkt1));

    axi_stream_pkt_arb #(.NUM_IN(4), .DAT_BITS(32), .MOD_BITS(2), .CTL_BITS(8),
                         .PIPE(0), .TAG_CTL(1)) u_tag (
        .i_clk(clk), .i_rst(rst), .i_axi(t_if), .o_axi(t_out),
        .o_sel(sel2), .o_lock(lock2), .o_pkt_cnt(pkt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present the oldest queued beat of every source.
    task automatic refresh();
        for (int k = 0; k < 4; k++) begin
            d_val[k] = 1'b0; d_dat[k] = 32'd0; d_ctl[k] = 8'd0;
            d_sop[k] = 1'b0; d_eop[k] = 1'b0;
            for (int i = 0; i < bq.size(); i++) begin
                if (bq[i].src == k && !d_val[k]) begin
                    d_val[k] = 1'b1; d_dat[k] = bq[i].dat; d_ctl[k] = bq[i].ctl;
                    d_sop[k] = bq[i].sop; d_eop[k] = bq[i].eop;
                end
            end
        end
    endtask

    task automatic pop_src(input int k);
        for (int i = 0; i < bq.size(); i++) begin
            if (bq[i].src == k) begin
                bq.delete(i);
                break;
            end
        end
    endtask

    task automatic push_pkt(input int src, input logic [31:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            bq.push_back('{src: src, dat: base + 32'(j), ctl: 8'h5A, sop: (j == 0), eop: (j == n - 1)});
        end
        refresh();
    endtask

    // One clock: sample handshakes before the edge, then advance the sources.
    task automatic cyc();
        logic [3:0] xf;
        logic       pop;
        @(negedge clk);
        xf  = d_val & d_rdy;
        pop = out_if.val && o_rdy;
        for (int k = 0; k < 4; k++) begin
            if (xf[k] && d_sop[k]) sel_log.push_back(int'(sel1));
        end
        if (rst) begin
            occ = 0;
        end else begin
            if (pop) obs_q.push_back(out_if.dat);
            occ = occ + int'(|xf) - int'(pop);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (xf[k]) pop_src(k);
        end
        refresh();
        #1;
    endtask

    function automatic logic [31:0] obs_at(input int i);
        return (i < obs_q.size()) ? obs_q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        n_assert = 0; n_fail = 0; occ = 0;
        rst = 1'b1; o_rdy = 1'b1; o2_rdy = 1'b1;
        t3_dat = 32'd0; t3_ctl = 8'd0; t3_sop = 1'b0; t3_eop = 1'b0; t3_err = 1'b0; t3_val = 1'b0;
        refresh();
        cyc(); cyc();
        chk("rst_val", 64'(out_if.val), 64'(0));
        chk("rst_lock", 64'(lock1), 64'(0));
        chk("rst_sel", 64'(sel1), 64'(3));
        chk("rst_cnt", 64'(pkt1), 64'(0));
        chk("rst_rdy", 64'(d_rdy), 64'(0));

        // Single 3-beat packet on input 0, two-cycle latency.
        rst = 1'b0;
        push_pkt(0, 32'hA0, 3);
        cyc();
        chk("t1_lock", 64'(lock1), 64'(1));
        chk("t1_sel", 64'(sel1), 64'(0));
        chk("t1_rdy", 64'(d_rdy), 64'(4'b0001));
        chk("t1_val_c1", 64'(out_if.val), 64'(0));
        cyc();
        chk("t1_val_c2", 64'(out_if.val), 64'(1));
        chk("t1_dat0", 64'(out_if.dat), 64'(32'hA0));
        chk("t1_sop0", 64'(out_if.sop), 64'(1));
        chk("t1_ctl0", 64'(out_if.ctl), 64'(8'h5A));
        chk("t1_mod0", 64'(out_if.mod), 64'(3));
        cyc();
        chk("t1_dat1", 64'(out_if.dat), 64'(32'hA1));
        cyc();
        chk("t1_dat2", 64'(out_if.dat), 64'(32'hA2));
        chk("t1_eop2", 64'(out_if.eop), 64'(1));
        chk("t1_unlock", 64'(lock1), 64'(0));
        cyc();
        chk("t1_idle_val", 64'(out_if.val), 64'(0));
        chk("t1_pkt", 64'(pkt1), 64'(1));
        chk("t1_nbeats", 64'(obs_q.size()), 64'(3));

        // Four simultaneous 2-beat packets from a fresh reset.
        rst = 1'b1;
        cyc();
        chk("t2_rst_cnt", 64'(pkt1), 64'(0));
        chk("t2_rst_sel", 64'(sel1), 64'(3));
        rst = 1'b0;
        obs_q.delete(); sel_log.delete();
        for (int k = 0; k < 4; k++) push_pkt(k, 32'hB0 + 32'(2 * k), 2);
        for (int i = 0; i < 40 && obs_q.size() < 8; i++) cyc();
        chk("t2_nbeats", 64'(obs_q.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("t2_beat", 64'(obs_at(i)), 64'(32'hB0 + 32'(i)));
        chk("t2_nsel", 64'(sel_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < sel_log.size(); i++) chk("t2_sel", 64'(sel_log[i]), 64'(i));
        chk("t2_pkt", 64'(pkt1), 64'(4));

        // 8-beat packet on input 1 under alternating backpressure.
        obs_q.delete();
        o_rdy = 1'b1;
        push_pkt(1, 32'hC0, 8);
        for (int i = 0; i < 60 && obs_q.size() < 8; i++) begin
            o_rdy = !o_rdy;
            cyc();
            if (lock1 && sel1 == 2'd1) chk("t3_rdy1", 64'(d_rdy[1]), 64'(occ != 2));
        end
        chk("t3_nbeats", 64'(obs_q.size()), 64'(8));
        for (int i = 0; i < 8; i++) chk("t3_beat", 64'(obs_at(i)), 64'(32'hC0 + 32'(i)));
        chk("t3_pkt", 64'(pkt1), 64'(5));

        // Input 2 requests while input 1 holds the lock.
        obs_q.delete();
        o_rdy = 1'b1;
        push_pkt(1, 32'hD0, 4);
        cyc();
        chk("t4_lock", 64'(lock1), 64'(1));
        chk("t4_sel1", 64'(sel1), 64'(1));
        push_pkt(2, 32'hE0, 1);
        cyc();
        chk("t4_rdy_mid", 64'(d_rdy), 64'(4'b0010));
        cyc(); cyc(); cyc();
        chk("t4_unlock", 64'(lock1), 64'(0));
        chk("t4_sel_hold", 64'(sel1), 64'(1));
        chk("t4_rdy_idle", 64'(d_rdy), 64'(0));
        cyc();
        chk("t4_regrant", 64'(lock1), 64'(1));
        chk("t4_sel2", 64'(sel1), 64'(2));
        chk("t4_rdy2", 64'(d_rdy), 64'(4'b0100));
        repeat (3) cyc();
        chk("t4_nbeats", 64'(obs_q.size()), 64'(5));
        for (int i = 0; i < 4; i++) chk("t4_beat", 64'(obs_at(i)), 64'(32'hD0 + 32'(i)));
        chk("t4_beat_e", 64'(obs_at(4)), 64'(32'hE0));
        chk("t4_pkt", 64'(pkt1), 64'(7));

        // Pass-through arbiter tags ctl with the source index.
        t3_val = 1'b1; t3_dat = 32'h55; t3_ctl = 8'hF0; t3_sop = 1'b1; t3_eop = 1'b0; t3_err = 1'b0;
        cyc();
        chk("t5_lock", 64'(lock2), 64'(1));
        chk("t5_sel", 64'(sel2), 64'(3));
        chk("t5_rdy", 64'(t_rdy), 64'(4'b1000));
        chk("t5_val0", 64'(t_out.val), 64'(1));
        chk("t5_ctl0", 64'(t_out.ctl), 64'(8'hF3));
        chk("t5_dat0", 64'(t_out.dat), 64'(32'h55));
        chk("t5_err0", 64'(t_out.err), 64'(0));
        cyc();
        t3_dat = 32'h56; t3_sop = 1'b0; t3_eop = 1'b1; t3_err = 1'b1;
        #1;
        chk("t5_ctl1", 64'(t_out.ctl), 64'(8'hF3));
        chk("t5_err1", 64'(t_out.err), 64'(1));
        chk("t5_eop1", 64'(t_out.eop), 64'(1));
        cyc();
        t3_val = 1'b0; t3_eop = 1'b0; t3_err = 1'b0;
        #1;
        chk("t5_idle_val", 64'(t_out.val), 64'(0));
        chk("t5_unlock", 64'(lock2), 64'(0));
        chk("t5_pkt", 64'(pkt2), 64'(1));

        // Reset with two beats held in the skid buffer.
        obs_q.delete();
        o_rdy = 1'b0;
        push_pkt(0, 32'h60, 5);
        cyc(); cyc(); cyc();
        chk("t6_full_rdy", 64'(d_rdy), 64'(0));
        chk("t6_full_val", 64'(out_if.val), 64'(1));
        chk("t6_full_dat", 64'(out_if.dat), 64'(32'h60));
        cyc();
        chk("t6_stall_dat", 64'(out_if.dat), 64'(32'h60));
        chk("t6_stall_lock", 64'(lock1), 64'(1));
        rst = 1'b1;
        bq.delete();
        refresh();
        cyc();
        chk("t6_rst_val", 64'(out_if.val), 64'(0));
        chk("t6_rst_rdy", 64'(d_rdy), 64'(0));
        chk("t6_rst_lock", 64'(lock1), 64'(0));
        chk("t6_rst_cnt", 64'(pkt1), 64'(0));
        push_pkt(0, 32'h70, 1);
        push_pkt(2, 32'h72, 1);
        rst = 1'b0;
        o_rdy = 1'b1;
        obs_q.delete();
        cyc();
        chk("t6_win_lock", 64'(lock1), 64'(1));
        chk("t6_win_sel", 64'(sel1), 64'(0));
        repeat (4) cyc();
        chk("t6_nbeats", 64'(obs_q.size()), 64'(2));
        chk("t6_beat0", 64'(obs_at(0)), 64'(32'h70));
        chk("t6_beat1", 64'(obs_at(1)), 64'(32'h72));
        chk("t6_pkt", 64'(pkt1), 64'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_stream_pkt_arb.md
Name: axi_stream_pkt_arb

Overview:
Packet-aware round-robin arbiter that shares one downstream if_axi_stream channel (typically the sink of a stream FIFO) among NUM_IN upstream sources. A grant is held from the first accepted beat until the beat carrying eop, so packets are never interleaved. An optional output skid stage registers the output while keeping full throughput. Status outputs expose the current grant, the lock state and a forwarded-packet count.

Parameters:
NUM_IN, 4, number of requesting sources (2..16)
DAT_BITS, 256, data width of every stream
MOD_BITS, $clog2(DAT_BITS/8), byte-modulus width
CTL_BITS, 8, ctl width; must be >= $clog2(NUM_IN) when TAG_CTL=1
PIPE, 1, 1 = registered 2-entry skid output stage; 0 = combinational pass-through
TAG_CTL, 0, 1 = replace ctl[$clog2(NUM_IN)-1:0] with the granted source index

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_axi  sink  if_axi_stream[NUM_IN] (dat DAT_BITS, ctl CTL_BITS, mod MOD_BITS, sop/eop/err/val/rdy 1)  requesters
o_axi  source  if_axi_stream (same widths)  arbitrated output
o_sel  output  $clog2(NUM_IN)  index of the current or last grant
o_lock  output  1  1 while a packet is in progress (state LOCK)
o_pkt_cnt  output  32  count of eop beats accepted on o_axi; wraps modulo 2^32

Behaviour:
- Reset (i_rst=1) values: state=IDLE, o_lock=0, o_sel=NUM_IN-1 (last_grant, so input 0 has first priority), o_axi.val=0, skid buffer empty, o_pkt_cnt=0, all i_axi[k].rdy=0 during reset.
- FSM IDLE:
  - All rdy=0.
  - If any i_axi[k].val=1, pick the first valid k in order last_grant+1, last_grant+2, … (mod NUM_IN).
  - Register o_sel<=k and go to LOCK.
  - Result: one grant cycle per packet.
- FSM LOCK:
  - i_axi[o_sel].rdy = output-stage ready; every other rdy=0.
  - A beat transfers when val&&rdy on the selected input.
  - A transferred beat with eop=1 goes to IDLE and updates last_grant.
  - Single-beat packets (sop=eop=1) take one LOCK cycle.
- The arbiter does not police sop. A beat with sop=0 in IDLE is still granted. sop/eop/err/mod/dat pass unmodified. ctl is unmodified except for the TAG_CTL substitution.
- PIPE=1 output stage:
  - Two-entry skid buffer; output-stage ready = buffer not full.
  - o_axi.val is registered. Latency: input val in IDLE at cycle 0, o_axi.val=1 at cycle 2.
  - Sustained 1 beat/cycle when o_axi.rdy=1.
  - Backpressure never loses or duplicates beats. The buffer drains in order.
- PIPE=0 output stage:
  - o_axi mirrors the selected input combinationally in LOCK; output-stage ready = o_axi.rdy.
  - o_axi.val=0 in IDLE.
- o_pkt_cnt increments on o_axi.val&&o_axi.rdy&&o_axi.eop. It wraps 0xFFFFFFFF to 0.
- Simultaneous events:
  - A new request arriving during LOCK waits; no preemption.
  - A requester that drops val mid-packet stalls the grant; the lock holds indefinitely.
  - The eop beat and a new request in the same cycle: the request is arbitrated in the next IDLE cycle.
- Reset mid-packet: the partial packet in the skid buffer is discarded, and o_axi.val=0 in the cycle after i_rst is sampled. The upstream partial packet remains the source's responsibility.

Test Plan:
1. NUM_IN=4, PIPE=1; only input 0 sends a 3-beat packet (dat 0xA0,0xA1,0xA2), o_axi.rdy=1 -> output beats identical and in order, first o_axi.val 2 cycles after input val, o_pkt_cnt=1, o_lock returns to 0.
2. All 4 inputs present 2-beat packets at the same cycle -> packets emitted in order 0,1,2,3 with no interleaving, o_sel sequence 0,1,2,3, o_pkt_cnt=4.
3. Input 1 sends an 8-beat packet while o_axi.rdy toggles 1,0,1,0 -> all 8 beats out exactly once in order; i_axi[1].rdy drops only when the skid buffer holds 2 entries.
4. Input 2 asserts val while input 1 is mid-packet -> i_axi[2].rdy=0 until input 1's eop transfers; input 2 is granted on the following IDLE cycle.
5. TAG_CTL=1, input 3 sends ctl=0xF0 -> o_axi.ctl=0xF3; err=1 on the last beat passes through as err=1.
6. i_rst pulsed mid-packet with 2 beats buffered -> next cycle o_axi.val=0, all rdy=0, o_lock=0, o_pkt_cnt=0; after release, input 0 wins against simultaneous input 2.
